// File: rtl/acondicionador_botones.sv
// acondicionador_botones: per-channel 2-flop synchronizer and debounce FSM giving a clean level and a press pulse.
// Optional macro AUTOREPEAT_EN adds hold-to-repeat pulses on the channels selected by REP_MASK.
module acondicionador_botones #(
   parameter int               N_BTN      = 4,
   parameter int               DEB_CYCLES = 500000,
   parameter int               CNT_W      = 20,
   parameter int               REP_DELAY  = 25000000,
   parameter int               REP_PERIOD = 10000000,
   parameter logic [N_BTN-1:0] REP_MASK   = N_BTN'(2'b11)
) (
   input  logic             Clock,
   input  logic             reset,
   input  logic [N_BTN-1:0] btn_raw,
   output logic [N_BTN-1:0] nivel,
   output logic [N_BTN-1:0] pulso
);

   localparam logic [1:0] SUELTO     = 2'd0;
   localparam logic [1:0] VALIDA_ON  = 2'd1;
   localparam logic [1:0] PRESIONADO = 2'd2;
   localparam logic [1:0] VALIDA_OFF = 2'd3;

   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

   if (DEB_CYCLES < 2 || (2 ** CNT_W) <= DEB_CYCLES || REP_PERIOD < 1 || REP_PERIOD > REP_DELAY)
   begin : g_param_check
      $error("acondicionador_botones: inconsistent debounce/repeat parameters");
   end

   logic [N_BTN-1:0] s1_q, s1_d;
   logic [N_BTN-1:0] s2_q, s2_d;

   always_comb begin
      s1_d = btn_raw;
      s2_d = s1_q;
   end

   always_ff @(posedge Clock or negedge reset) begin
      if (!reset) begin
         s1_q <= '0;
         s2_q <= '0;
      end else begin
         s1_q <= s1_d;
         s2_q <= s2_d;
      end
   end

   for (genvar gi = 0; gi < N_BTN; gi++) begin : g_ch
      logic [1:0]       state_q, state_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             nivel_q, nivel_d;
      logic             pulso_q, pulso_d;
      logic             press;
      logic             rep_pulse;

      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         nivel_d = nivel_q;
         press   = 1'b0;
         case (state_q)
            SUELTO: begin
               cnt_d = '0;
               if (s2_q[gi]) state_d = VALIDA_ON;
            end
            VALIDA_ON: begin
               if (!s2_q[gi]) begin
                  state_d = SUELTO;
                  cnt_d   = '0;
               end else if (cnt_q == DEB_LAST) begin
                  state_d = PRESIONADO;
                  cnt_d   = '0;
                  nivel_d = 1'b1;
                  press   = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            PRESIONADO: begin
               cnt_d = '0;
               if (!s2_q[gi]) state_d = VALIDA_OFF;
            end
            default: begin
               // VALIDA_OFF: a return to 1 before the count completes is a release glitch
               if (s2_q[gi]) begin
                  state_d = PRESIONADO;
                  cnt_d   = '0;
               end else if (cnt_q == DEB_LAST) begin
                  state_d = SUELTO;
                  cnt_d   = '0;
                  nivel_d = 1'b0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         endcase
      end

`ifdef AUTOREPEAT_EN
      if (REP_MASK[gi]) begin : g_rep
         localparam int RCNT_W = $clog2(REP_DELAY) + 1;
         logic [RCNT_W-1:0] rcnt_q, rcnt_d;
         logic              rep_fire;

         // Counts hold time while the debounced level stays high; reloads so later repeats are REP_PERIOD apart.
         always_comb begin
            rcnt_d   = '0;
            rep_fire = 1'b0;
            if (!press && nivel_q && nivel_d) begin
               if (rcnt_q == RCNT_W'(REP_DELAY - 1)) begin
                  rep_fire = 1'b1;
                  rcnt_d   = RCNT_W'(REP_DELAY - REP_PERIOD);
               end else begin
                  rcnt_d = rcnt_q + RCNT_W'(1);
               end
            end
         end

         always_ff @(posedge Clock or negedge reset) begin
            if (!reset) rcnt_q <= '0;
            else        rcnt_q <= rcnt_d;
         end

         assign rep_pulse = rep_fire;
      end else begin : g_norep
         assign rep_pulse = 1'b0;
      end
`else
      assign rep_pulse = 1'b0;
`endif

      assign pulso_d = press | rep_pulse;

      always_ff @(posedge Clock or negedge reset) begin
         if (!reset) begin
            state_q <= SUELTO;
            cnt_q   <= '0;
            nivel_q <= 1'b0;
            pulso_q <= 1'b0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            nivel_q <= nivel_d;
            pulso_q <= pulso_d;
         end
      end

      assign nivel[gi] = nivel_q;
      assign pulso[gi] = pulso_q;
   end

endmodule

// File: tb/tb_acondicionador_botones.sv
// Bench for acondicionador_botones: directed timeline checks plus randomized bouncing inputs against a
// run-length behavioural model; honours AUTOREPEAT_EN when defined for both files.
`timescale 1ns/1ps
module tb_acondicionador_botones;
   localparam int         N   = 4;
   localparam int         DEB = 4;
   localparam int         CW  = 3;
   localparam int         RD  = 12;
   localparam int         RP  = 5;
   localparam logic [3:0] RM  = 4'b0011;
`ifdef AUTOREPEAT_EN
   localparam int EXP_UP_PULSES = 6;
`else
   localparam int EXP_UP_PULSES = 1;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] raw = 4'b0;
   logic [3:0] nivel, pulso;
   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   acondicionador_botones #(
      .N_BTN(N), .DEB_CYCLES(DEB), .CNT_W(CW), .REP_DELAY(RD), .REP_PERIOD(RP), .REP_MASK(RM)
   ) dut (
      .Clock(clk), .reset(rst_n), .btn_raw(raw), .nivel(nivel), .pulso(pulso)
   );

   // Behavioural model: the debouncer sees raw delayed two edges; the level flips once the seen value
   // has disagreed with it for DEB+1 consecutive edges. Repeats are a function of hold time since press.
   bit [3:0]   dly[$] = '{4'b0, 4'b0};
   logic [3:0] m_nivel = 4'b0;
   logic [3:0] m_pulso = 4'b0;
   int         run[N];
   int         hold[N];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dly = '{4'b0, 4'b0};
         m_nivel = '0;
         m_pulso = '0;
         for (int i = 0; i < N; i++) begin
            run[i] = 0;
            hold[i] = 0;
         end
      end else begin
         bit [3:0] seen;
         seen = dly.pop_front();
         dly.push_back(raw);
         for (int i = 0; i < N; i++) begin
            m_pulso[i] = 1'b0;
            if (seen[i] != m_nivel[i]) run[i]++;
            else run[i] = 0;
            if (run[i] == DEB + 1) begin
               m_nivel[i] = seen[i];
               run[i] = 0;
               if (seen[i]) begin
                  m_pulso[i] = 1'b1;
                  hold[i] = 0;
               end
            end else if (m_nivel[i]) begin
               hold[i]++;
`ifdef AUTOREPEAT_EN
               if (RM[i] && (hold[i] == RD || (hold[i] > RD && (hold[i] - RD) % RP == 0)))
                  m_pulso[i] = 1'b1;
`endif
            end
         end
      end
   end

   always @(negedge clk) begin
      checks++;
      if (nivel !== m_nivel) begin
         errors++;
         $display("FAIL model_nivel cyc=%0d got=%b exp=%b", cyc, nivel, m_nivel);
      end
      checks++;
      if (pulso !== m_pulso) begin
         errors++;
         $display("FAIL model_pulso cyc=%0d got=%b exp=%b", cyc, pulso, m_pulso);
      end
   end

   task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%b exp=%b", name, cyc, got, exp);
      end
   endtask

   task automatic check_int(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, got, exp);
      end
   endtask

   task automatic at_edge();
      @(posedge clk);
      #2;
   endtask

   // Called just after inputs change; the next edge samples them, outputs respond 6 edges later.
   task automatic press_timeline(input logic [3:0] mask, input string tag);
      repeat (7) @(negedge clk);
      check({tag, "_pre_nivel"}, nivel & mask, 4'b0);
      check({tag, "_pre_pulso"}, pulso & mask, 4'b0);
      @(negedge clk);
      check({tag, "_nivel"}, nivel & mask, mask);
      check({tag, "_pulso"}, pulso & mask, mask);
      check({tag, "_model_pulso"}, m_pulso & mask, mask);
      @(negedge clk);
      check({tag, "_pulso_end"}, pulso & mask, 4'b0);
      $display("press %s mask=%b cyc=%0d", tag, mask, cyc);
   endtask

   task automatic release_timeline(input logic [3:0] mask, input string tag);
      repeat (7) @(negedge clk);
      check({tag, "_pre_nivel"}, nivel & mask, mask);
      @(negedge clk);
      check({tag, "_nivel"}, nivel & mask, 4'b0);
      check({tag, "_pulso"}, pulso & mask, 4'b0);
      $display("release %s mask=%b cyc=%0d", tag, mask, cyc);
   endtask

   initial begin
      logic any_out;
      logic all_high;
      int   cnt_up, cnt_tc;
      int   dur[N];

      repeat (3) @(negedge clk);
      check("reset_nivel", nivel, 4'b0);
      check("reset_pulso", pulso, 4'b0);
      at_edge();
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // Clean press and release on Up
      at_edge(); raw = 4'b0001;
      press_timeline(4'b0001, "clean");
      at_edge(); raw = 4'b0000;
      release_timeline(4'b0001, "clean_rel");
      repeat (3) @(negedge clk);

      // Bounce on Down: highs of 2 cycles never qualify
      any_out = 1'b0;
      for (int b = 0; b < 2; b++) begin
         at_edge(); raw[1] = 1'b1;
         at_edge();
         at_edge(); raw[1] = 1'b0;
         at_edge();
      end
      repeat (14) begin
         @(negedge clk);
         any_out = any_out | nivel[1] | pulso[1];
      end
      check("bounce_quiet", {3'b0, any_out}, 4'b0);
      $display("bounce ch1 cyc=%0d", cyc);

      // Release glitch on TC: 3-cycle drop while held
      at_edge(); raw[2] = 1'b1;
      press_timeline(4'b0100, "glitch_press");
      at_edge(); raw[2] = 1'b0;
      at_edge();
      at_edge();
      at_edge(); raw[2] = 1'b1;
      all_high = 1'b1;
      any_out = 1'b0;
      repeat (14) begin
         @(negedge clk);
         all_high = all_high & nivel[2];
         any_out = any_out | pulso[2];
      end
      check("glitch_level_held", {3'b0, all_high}, 4'b0001);
      check("glitch_no_pulse", {3'b0, any_out}, 4'b0);
      $display("glitch ch2 cyc=%0d", cyc);
      at_edge(); raw[2] = 1'b0;
      release_timeline(4'b0100, "glitch_rel");
      repeat (3) @(negedge clk);

      // Simultaneous press/release of all channels
      at_edge(); raw = 4'b1111;
      press_timeline(4'b1111, "simul");
      repeat (4) @(negedge clk);
      at_edge(); raw = 4'b0000;
      release_timeline(4'b1111, "simul_rel");
      repeat (3) @(negedge clk);

      // Long hold on Up and TC: only Up may repeat
      at_edge(); raw = 4'b0101;
      press_timeline(4'b0101, "hold");
      cnt_up = 1;
      cnt_tc = 1;
      repeat (34) begin
         @(negedge clk);
         cnt_up += int'(pulso[0]);
         cnt_tc += int'(pulso[2]);
      end
      check_int("hold_up_pulses", cnt_up, EXP_UP_PULSES);
      check_int("hold_tc_pulses", cnt_tc, 1);
      $display("hold up=%0d tc=%0d cyc=%0d", cnt_up, cnt_tc, cyc);
      at_edge(); raw = 4'b0000;
      release_timeline(4'b0101, "hold_rel");
      repeat (3) @(negedge clk);

      // Reset in the middle of Lp validation while Up is held
      at_edge(); raw = 4'b0001;
      press_timeline(4'b0001, "pre_reset");
      at_edge(); raw = 4'b1001;
      repeat (5) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midreset_nivel", nivel, 4'b0);
      check("midreset_pulso", pulso, 4'b0);
      $display("reset asserted cyc=%0d", cyc);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      press_timeline(4'b1001, "after_reset");
      at_edge(); raw = 4'b0000;
      release_timeline(4'b1001, "after_reset_rel");
      repeat (3) @(negedge clk);

      // Randomized bouncing inputs with occasional short resets
      for (int i = 0; i < N; i++) dur[i] = $urandom_range(1, 10);
      for (int c = 0; c < 2500; c++) begin
         at_edge();
         rst_n = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
         for (int i = 0; i < N; i++) begin
            if (dur[i] == 0) begin
               int r;
               raw[i] = ~raw[i];
               r = $urandom_range(0, 9);
               if (r < 5)      dur[i] = $urandom_range(1, 4);
               else if (r < 9) dur[i] = $urandom_range(5, 12);
               else            dur[i] = $urandom_range(20, 45);
            end else begin
               dur[i]--;
            end
         end
      end
      at_edge();
      rst_n = 1'b1;
      raw = 4'b0000;
      repeat (12) @(negedge clk);
      $display("random phase done cyc=%0d", cyc);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
